// File: rtl/traffic_phase_ctrl.sv
`timescale 1ns/1ps
// traffic_phase_ctrl -- phase sequencer for a two-road signalised intersection.
//
// Steps RED_TO_MAIN -> MAIN_G -> MAIN_Y -> RED_TO_SEC -> SEC_G -> SEC_Y on the
// 1 s tick. Main green is re-armed while nobody waits on the secondary road.
// A night request is honoured only at all-red expiry and gives flashing yellow.
//
// Ports:
//   clk, rst (async, active-low)      clock and reset
//   tick                              one-clk pulse per second
//   enable                            0 freezes state, counter and lamps
//   night_mode                        flashing-yellow request
//   sec_sensor                        vehicle waiting on the secondary road
//   main_r/y/g, sec_r/y/g             lamp drivers
//   state                             current phase encoding
//   time_left                         ticks remaining in the phase minus 1
//   ped_req / ped_walk                pedestrian button / walk lamp
//                                     (only when PED_REQ_EN is defined)
//
// Optional feature macro: PED_REQ_EN.
//
// traffic_phase_ctrl_chk -- lamp-safety checker, bound from the bench.
module traffic_phase_ctrl #(
  parameter int T_MAIN_G = 20,
  parameter int T_MAIN_Y = 3,
  parameter int T_ALL_R  = 2,
  parameter int T_SEC_G  = 10,
  parameter int T_SEC_Y  = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             enable,
  input  logic             night_mode,
  input  logic             sec_sensor,
`ifdef PED_REQ_EN
  input  logic             ped_req,
  output logic             ped_walk,
`endif
  output logic             main_r,
  output logic             main_y,
  output logic             main_g,
  output logic             sec_r,
  output logic             sec_y,
  output logic             sec_g,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] time_left
);

  typedef enum logic [2:0] {
    RED_TO_MAIN = 3'd0,
    MAIN_G      = 3'd1,
    MAIN_Y      = 3'd2,
    RED_TO_SEC  = 3'd3,
    SEC_G       = 3'd4,
    SEC_Y       = 3'd5,
    FLASH       = 3'd6,
    UNUSED_7    = 3'd7
  } phase_t;

  localparam logic [CNT_W-1:0] LD_MAIN_G = CNT_W'(T_MAIN_G - 1);
  localparam logic [CNT_W-1:0] LD_MAIN_Y = CNT_W'(T_MAIN_Y - 1);
  localparam logic [CNT_W-1:0] LD_ALL_R  = CNT_W'(T_ALL_R - 1);
  localparam logic [CNT_W-1:0] LD_SEC_G  = CNT_W'(T_SEC_G - 1);
  localparam logic [CNT_W-1:0] LD_SEC_Y  = CNT_W'(T_SEC_Y - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [5:0]       ALL_RED   = 6'b100_100;

  // Lamp pattern {main_r,main_y,main_g,sec_r,sec_y,sec_g}; anything unknown is all-red.
  function automatic logic [5:0] lamps_of(input phase_t ph, input logic fl);
    logic [5:0] l;
    l = ALL_RED;
    case (ph)
      MAIN_G:  l = 6'b001_100;
      MAIN_Y:  l = 6'b010_100;
      SEC_G:   l = 6'b100_001;
      SEC_Y:   l = 6'b100_010;
      FLASH:   l = {1'b0, fl, 1'b0, 1'b0, fl, 1'b0};
      default: l = ALL_RED;
    endcase
    return l;
  endfunction

  phase_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             flash_r, flash_s;
  logic [5:0]       lamp_r, lamp_s;
  logic             step_s;
  logic             ext_req_s;

  assign step_s = enable & tick;

`ifdef PED_REQ_EN
  logic ped_prev_r, ped_pend_r, ped_pend_s, walk_r;

  // Sticky pedestrian request: set on a button rising edge, cleared on SEC_G entry.
  always_comb begin
    ped_pend_s = ped_pend_r | (ped_req & ~ped_prev_r);
    if ((state_s == SEC_G) && (state_r != SEC_G)) begin
      ped_pend_s = 1'b0;
    end else begin
      ped_pend_s = ped_pend_s;
    end
  end

  // Pedestrian edge register, pending flag and walk lamp (walk tracks next phase).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ped_prev_r <= 1'b0;
      ped_pend_r <= 1'b0;
      walk_r     <= 1'b0;
    end else begin
      ped_prev_r <= ped_req;
      ped_pend_r <= ped_pend_s;
      walk_r     <= (state_s == SEC_G);
    end
  end

  assign ped_walk  = walk_r;
  assign ext_req_s = sec_sensor | ped_pend_r;
`else
  assign ext_req_s = sec_sensor;
`endif

  // Next phase, counter and flash bit; lamps are decoded from the next phase so
  // the registered lamps change on the same edge as the state register.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    flash_s = 1'b0;
    if (state_r == UNUSED_7) begin
      state_s = RED_TO_MAIN;
      cnt_s   = LD_ALL_R;
    end else if (!step_s) begin
      flash_s = flash_r;
    end else if (state_r == FLASH) begin
      cnt_s = CNT_ZERO;
      if (night_mode) begin
        flash_s = ~flash_r;
      end else begin
        state_s = RED_TO_MAIN;
        cnt_s   = LD_ALL_R;
      end
    end else if (cnt_r != CNT_ZERO) begin
      cnt_s = cnt_r - CNT_ONE;
    end else begin
      case (state_r)
        RED_TO_MAIN: begin
          if (night_mode) begin
            state_s = FLASH;
            cnt_s   = CNT_ZERO;
          end else begin
            state_s = MAIN_G;
            cnt_s   = LD_MAIN_G;
          end
        end
        MAIN_G: begin
          // No demand from the side road: re-arm main green instead of leaving.
          if (ext_req_s) begin
            state_s = MAIN_Y;
            cnt_s   = LD_MAIN_Y;
          end else begin
            state_s = MAIN_G;
            cnt_s   = LD_MAIN_G;
          end
        end
        MAIN_Y: begin
          state_s = RED_TO_SEC;
          cnt_s   = LD_ALL_R;
        end
        RED_TO_SEC: begin
          if (night_mode) begin
            state_s = FLASH;
            cnt_s   = CNT_ZERO;
          end else begin
            state_s = SEC_G;
            cnt_s   = LD_SEC_G;
          end
        end
        SEC_G: begin
          state_s = SEC_Y;
          cnt_s   = LD_SEC_Y;
        end
        SEC_Y: begin
          state_s = RED_TO_MAIN;
          cnt_s   = LD_ALL_R;
        end
        default: begin
          state_s = RED_TO_MAIN;
          cnt_s   = LD_ALL_R;
        end
      endcase
    end
    lamp_s = lamps_of(state_s, flash_s);
  end

  // Phase, counter, flash and lamp registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RED_TO_MAIN;
      cnt_r   <= LD_ALL_R;
      flash_r <= 1'b0;
      lamp_r  <= ALL_RED;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      flash_r <= flash_s;
      lamp_r  <= lamp_s;
    end
  end

  assign {main_r, main_y, main_g, sec_r, sec_y, sec_g} = lamp_r;
  assign state     = state_r;
  assign time_left = cnt_r;

endmodule

module traffic_phase_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic main_r,
  input logic main_y,
  input logic main_g,
  input logic sec_r,
  input logic sec_y,
  input logic sec_g
);
  a_no_dual_green: assert property (@(posedge clk) disable iff (!rst) !(main_g && sec_g));
  a_one_main_lamp: assert property (@(posedge clk) disable iff (!rst)
                                    $countones({main_r, main_y, main_g}) <= 1);
  a_one_sec_lamp:  assert property (@(posedge clk) disable iff (!rst)
                                    $countones({sec_r, sec_y, sec_g}) <= 1);
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
`timescale 1ns/1ps
module tb_traffic_phase_ctrl;

  logic       clk, rst, tick, enable, night_mode, sec_sensor;
  logic       main_r, main_y, main_g, sec_r, sec_y, sec_g;
  logic [2:0] state;
  logic [7:0] time_left;
  logic [5:0] lamps_obs;
`ifdef PED_REQ_EN
  logic       ped_req, ped_walk;
`endif

  traffic_phase_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable),
    .night_mode(night_mode), .sec_sensor(sec_sensor),
`ifdef PED_REQ_EN
    .ped_req(ped_req), .ped_walk(ped_walk),
`endif
    .main_r(main_r), .main_y(main_y), .main_g(main_g),
    .sec_r(sec_r), .sec_y(sec_y), .sec_g(sec_g),
    .state(state), .time_left(time_left)
  );

  traffic_phase_ctrl_chk u_chk (
    .clk(clk), .rst(rst), .main_r(main_r), .main_y(main_y), .main_g(main_g),
    .sec_r(sec_r), .sec_y(sec_y), .sec_g(sec_g)
  );

  assign lamps_obs = {main_r, main_y, main_g, sec_r, sec_y, sec_g};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [7:0] tl;
    logic [5:0] lamps;
    logic       walk;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   walk_cnt = 0;

  // Reference model state (durations in ticks per phase; FLASH holds 0).
  int   dur_tab[7] = '{2, 20, 3, 2, 10, 3, 1};
  int   m_state, m_tl;
  bit   m_flash, m_pend;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [5:0] exp_lamps(input int s, input bit f);
    case (s)
      1:       return 6'b001_100;
      2:       return 6'b010_100;
      4:       return 6'b100_001;
      5:       return 6'b100_010;
      6:       return {1'b0, f, 1'b0, 1'b0, f, 1'b0};
      default: return 6'b100_100;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_tl = dur_tab[0] - 1; m_flash = 1'b0; m_pend = 1'b0;
  endtask

  task automatic model_step();
    int ns;
    ns = m_state;
    if (m_state == 6) begin
      if (night_mode) begin
        m_flash = ~m_flash;
      end else begin
        m_state = 0; m_tl = dur_tab[0] - 1; m_flash = 1'b0;
      end
    end else if (m_tl > 0) begin
      m_tl--;
    end else begin
      case (m_state)
        0: ns = night_mode ? 6 : 1;
        1: ns = (sec_sensor || m_pend) ? 2 : 1;
        2: ns = 3;
        3: ns = night_mode ? 6 : 4;
        4: ns = 5;
        default: ns = 0;
      endcase
      if (ns == 4) m_pend = 1'b0;
      m_state = ns;
      m_tl = dur_tab[ns] - 1;
    end
  endtask

  // One tick pulse: expectation pushed when the pulse is driven, compared after the edge.
  task automatic tick_once();
    exp_t e;
    @(negedge clk);
    tick = 1'b1;
    if (enable) model_step();
    e.st = 3'(m_state); e.tl = 8'(m_tl);
    e.lamps = exp_lamps(m_state, m_flash); e.walk = (m_state == 4);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    tick = 1'b0;
    e = sb_q.pop_front();
    chk("state", int'(state), int'(e.st));
    chk("time_left", int'(time_left), int'(e.tl));
    chk("lamps", int'(lamps_obs), int'(e.lamps));
`ifdef PED_REQ_EN
    chk("ped_walk", int'(ped_walk), int'(e.walk));
    if (ped_walk) walk_cnt++;
`endif
    repeat (3) @(posedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_once();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; enable = 1'b0; night_mode = 1'b0; sec_sensor = 1'b1;
`ifdef PED_REQ_EN
    ped_req = 1'b0;
`endif
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_state", int'(state), 0);
    chk("rst_time_left", int'(time_left), 1);
    chk("rst_lamps", int'(lamps_obs), int'(6'b100_100));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    enable = 1'b1;

    // Full normal cycle plus entry into the next main green.
    ticks(42);
    chk("cycle_state", int'(state), 1);
    chk("cycle_time_left", int'(time_left), 19);

    // Extension with nobody waiting, then demand appears.
    sec_sensor = 1'b0;
    ticks(20);
    chk("ext_state", int'(state), 1);
    chk("ext_reload", int'(time_left), 19);
    sec_sensor = 1'b1;
    ticks(19);
    chk("ext_hold", int'(state), 1);
    ticks(1);
    chk("ext_to_main_y", int'(state), 2);

    // Freeze with enable low at MAIN_Y, time_left=1.
    ticks(1);
    enable = 1'b0;
    ticks(10);
    chk("freeze_state", int'(state), 2);
    chk("freeze_time_left", int'(time_left), 1);
    enable = 1'b1;
    ticks(2);
    chk("resume_red_to_sec", int'(state), 3);

    // Night request during SEC_G: finishes secondary phases, then flashes.
    ticks(2);
    night_mode = 1'b1;
    ticks(13);
    chk("night_red_to_main", int'(state), 0);
    ticks(2);
    chk("night_flash", int'(state), 6);
    ticks(3);
    chk("flash_yellow", int'(main_y), 1);
    chk("flash_time_left", int'(time_left), 0);
    night_mode = 1'b0;
    ticks(1);
    chk("flash_exit", int'(state), 0);
    ticks(2);
    chk("flash_main_g", int'(state), 1);

    // Asynchronous reset in the middle of SEC_G.
    ticks(25);
    chk("pre_rst_sec_g", int'(state), 4);
    ticks(3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_lamps", int'(lamps_obs), int'(6'b100_100));
    @(negedge clk);
    #2 rst = 1'b1;
    chk("post_rst_time_left", int'(time_left), 1);
    ticks(3);

`ifdef PED_REQ_EN
    // Pedestrian request while main green would otherwise extend.
    sec_sensor = 1'b0;
    walk_cnt = 0;
    ticks(5);
    ped_req = 1'b1;
    m_pend = 1'b1;
    repeat (2) @(posedge clk);
    ticks(14);
    chk("ped_main_y", int'(state), 2);
    ticks(5);
    chk("ped_sec_g", int'(state), 4);
    ticks(15);
    ticks(20);
    chk("ped_no_retrigger", int'(state), 1);
    chk("ped_walk_ticks", walk_cnt, 10);
    ped_req = 1'b0;
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
